rsa_operand_sequencer: RTL and testbench

//  Upstream feeder for the Montgomery exponentiator.
//  - Assembles the 128-bit message, exponent and modulus from 16-bit word writes.
//  - Validates the operands, then runs the go/done handshake with the engine.
//  - Latches the result and serves it back as 16-bit words for the display path.
//  - Sits between the stimulus/PicoBlaze word interface and the exponentiator.

---
 rtl/rsa_pkg.sv | 20 ++
 rtl/rsa_word_bank.sv | 30 +++
 rtl/rsa_operand_sequencer.sv | 160 ++++++++++++++++
 tb/tb_rsa_operand_sequencer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared widths, select codes and FSM states for the RSA operand sequencer
package rsa_pkg;

  localparam int BITS  = 128;
  localparam int WORD  = 16;
  localparam int WORDS = BITS / WORD;
  localparam int AW    = $clog2(WORDS);

  localparam logic [1:0] SEL_M = 2'd0;
  localparam logic [1:0] SEL_E = 2'd1;
  localparam logic [1:0] SEL_N = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CHECK   = 2'd1,
    ST_RUN     = 2'd2,
    ST_CAPTURE = 2'd3
  } state_e;

endpackage

// File: rtl/rsa_word_bank.sv
// rtl/rsa_word_bank.sv - WORDS x WORD operand register bank with a word write port and flat output
module rsa_word_bank
  import rsa_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            en_i,
  input  logic [AW-1:0]   addr_i,
  input  logic [WORD-1:0] data_i,
  output logic [BITS-1:0] q_o
);

  logic [WORD-1:0] mem_q [WORDS];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (en_i) begin
      mem_q[addr_i] <= data_i;
    end
  end

  // Word 0 is the least-significant slice of the flat operand.
  for (genvar g = 0; g < WORDS; g++) begin : g_flat
    assign q_o[g*WORD +: WORD] = mem_q[g];
  end

endmodule

// File: rtl/rsa_operand_sequencer.sv
// rtl/rsa_operand_sequencer.sv - operand assembly, validation and go/done handshake for the exponentiator
// Optional engine watchdog: RSA_SEQ_TIMEOUT_EN
module rsa_operand_sequencer
  import rsa_pkg::*;
`ifdef RSA_SEQ_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 32'd1 << 20
)
`endif
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            wr_en,
  input  logic [1:0]      wr_sel,
  input  logic [AW-1:0]   wr_addr,
  input  logic [WORD-1:0] wr_data,
  input  logic            start,
  input  logic            abort,
  output logic [BITS-1:0] m,
  output logic [BITS-1:0] e,
  output logic [BITS-1:0] n,
  output logic            go,
  input  logic            eng_done,
  input  logic [BITS-1:0] eng_r,
  input  logic [AW-1:0]   rd_addr,
  output logic [WORD-1:0] rd_data,
  output logic            busy,
  output logic            done,
  output logic            err
);

  state_e          state_q, state_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [BITS-1:0] result_q, result_d;
  logic            wr_ok;
  logic            operands_bad;

`ifdef RSA_SEQ_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] cnt_q, cnt_d;
`endif

  // Operands are frozen outside IDLE so the engine sees stable inputs.
  assign wr_ok = wr_en && (state_q == ST_IDLE);

  rsa_word_bank u_bank_m (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (wr_ok && (wr_sel == SEL_M)),
    .addr_i  (wr_addr),
    .data_i  (wr_data),
    .q_o     (m)
  );

  rsa_word_bank u_bank_e (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (wr_ok && (wr_sel == SEL_E)),
    .addr_i  (wr_addr),
    .data_i  (wr_data),
    .q_o     (e)
  );

  rsa_word_bank u_bank_n (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (wr_ok && (wr_sel == SEL_N)),
    .addr_i  (wr_addr),
    .data_i  (wr_data),
    .q_o     (n)
  );

  // Montgomery needs an odd, non-zero modulus strictly above the message.
  assign operands_bad = (n == '0) || !n[0] || (m >= n);

  always_comb begin
    state_d  = state_q;
    done_d   = done_q;
    err_d    = err_q;
    result_d = result_q;
`ifdef RSA_SEQ_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CHECK;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      ST_CHECK: begin
        if (operands_bad) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
`ifdef RSA_SEQ_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_RUN: begin
`ifdef RSA_SEQ_TIMEOUT_EN
        cnt_d = cnt_q + 32'd1;
`endif
        // Result and done are registered on the eng_done edge so done
        // follows eng_done by exactly one edge; CAPTURE only retires busy.
        if (abort) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
        end else if (eng_done) begin
          state_d  = ST_CAPTURE;
          result_d = eng_r;
          done_d   = 1'b1;
        end
`ifdef RSA_SEQ_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end
`endif
      end
      ST_CAPTURE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
`ifdef RSA_SEQ_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      err_q    <= err_d;
      result_q <= result_d;
`ifdef RSA_SEQ_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign go      = (state_q == ST_RUN);
  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;
  assign err     = err_q;
  assign rd_data = result_q[rd_addr*WORD +: WORD];

endmodule

// File: tb/tb_rsa_operand_sequencer.sv
// tb/tb_rsa_operand_sequencer.sv - directed self-checking bench for rsa_operand_sequencer
module tb_rsa_operand_sequencer;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         wr_en;
  logic [1:0]   wr_sel;
  logic [2:0]   wr_addr;
  logic [15:0]  wr_data;
  logic         start;
  logic         abort;
  logic [127:0] m, e, n;
  logic         go;
  logic         eng_done;
  logic [127:0] eng_r;
  logic [2:0]   rd_addr;
  logic [15:0]  rd_data;
  logic         busy, done, err;

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_result;

  always #10 clk = ~clk;

`ifdef RSA_SEQ_TIMEOUT_EN
  rsa_operand_sequencer #(.TIMEOUT_CYCLES(16)) dut (
`else
  rsa_operand_sequencer dut (
`endif
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .start    (start),
    .abort    (abort),
    .m        (m),
    .e        (e),
    .n        (n),
    .go       (go),
    .eng_done (eng_done),
    .eng_r    (eng_r),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [1:0] sel, input logic [2:0] addr, input logic [15:0] data);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_addr = addr;
    wr_data = data;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic load_ops(input logic [127:0] mv, input logic [127:0] ev, input logic [127:0] nv);
    for (int i = 0; i < 8; i++) begin
      write_word(2'd0, i[2:0], mv[i*16 +: 16]);
      write_word(2'd1, i[2:0], ev[i*16 +: 16]);
      write_word(2'd2, i[2:0], nv[i*16 +: 16]);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    checks++; if (go !== 1'b0)   begin errors++; $display("FAIL reset_go: got %b want 0", go); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (err !== 1'b0)  begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if ((m | e | n) !== 128'd0) begin errors++; $display("FAIL reset_operands: m=%h e=%h n=%h want 0", m, e, n); end
    rd_addr = 3'd0; #1;
    checks++; if (rd_data !== 16'h0000) begin errors++; $display("FAIL reset_rd_data: got %h want 0000", rd_data); end
  endtask

  task automatic test_basic_run();
    load_ops(128'd2, 128'd3, 128'd13);
    pulse_start();
    checks++; if (go !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL basic_check_state: go=%b busy=%b want 0/1", go, busy); end
    tick();
    checks++; if (go !== 1'b1) begin errors++; $display("FAIL basic_go_latency: got %b want 1", go); end
    checks++; if (m !== 128'd2 || e !== 128'd3 || n !== 128'd13) begin errors++; $display("FAIL basic_operands: m=%h e=%h n=%h", m, e, n); end
    repeat (9) tick();
    eng_r = 128'd8;
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    eng_r = '0;
    checks++; if (done !== 1'b1 || go !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL basic_done: done=%b go=%b err=%b want 1/0/0", done, go, err); end
    rd_addr = 3'd0; #1;
    checks++; if (rd_data !== 16'h0008) begin errors++; $display("FAIL basic_result: got %h want 0008", rd_data); end
    exp_result = 128'd8;
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL basic_idle: busy=%b done=%b want 0/1", busy, done); end
    write_word(2'd1, 3'd0, 16'd3);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL write_keeps_done: got %b want 1", done); end
  endtask

  task automatic test_bad_operands();
    write_word(2'd2, 3'd0, 16'h000C);
    pulse_start();
    checks++; if (err !== 1'b0 || done !== 1'b0 || go !== 1'b0) begin errors++; $display("FAIL even_n_check_cycle: err=%b done=%b go=%b want 0/0/0", err, done, go); end
    tick();
    checks++; if (err !== 1'b1 || busy !== 1'b0 || go !== 1'b0) begin errors++; $display("FAIL even_n: err=%b busy=%b go=%b want 1/0/0", err, busy, go); end
    write_word(2'd2, 3'd0, 16'd13);
    write_word(2'd0, 3'd0, 16'd13);
    pulse_start();
    tick();
    checks++; if (err !== 1'b1 || go !== 1'b0) begin errors++; $display("FAIL m_ge_n: err=%b go=%b want 1/0", err, go); end
    write_word(2'd2, 3'd0, 16'd0);
    pulse_start();
    tick();
    checks++; if (err !== 1'b1 || go !== 1'b0) begin errors++; $display("FAIL n_zero: err=%b go=%b want 1/0", err, go); end
    write_word(2'd3, 3'd0, 16'd7);
    checks++; if (m !== 128'd13 || e !== 128'd3 || n !== 128'd0) begin errors++; $display("FAIL sel3_dropped: m=%h e=%h n=%h", m, e, n); end
  endtask

  task automatic test_write_with_start();
    write_word(2'd2, 3'd0, 16'd13);
    wr_en = 1'b1; wr_sel = 2'd0; wr_addr = 3'd0; wr_data = 16'd2;
    start = 1'b1;
    tick();
    wr_en = 1'b0;
    start = 1'b0;
    tick();
    checks++; if (go !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL write_with_start: go=%b err=%b want 1/0", go, err); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (go !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_run: go=%b busy=%b done=%b want 0/0/0", go, busy, done); end
  endtask

  task automatic test_write_during_run();
    pulse_start();
    tick();
    checks++; if (go !== 1'b1) begin errors++; $display("FAIL wrun_go: got %b want 1", go); end
    write_word(2'd0, 3'd0, 16'hFFFF);
    checks++; if (m !== 128'd2) begin errors++; $display("FAIL wrun_m_frozen: got %h want 2", m); end
    eng_r = {96'd0, 16'hABCD, 16'h0005};
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    eng_r = '0;
    exp_result = {96'd0, 16'hABCD, 16'h0005};
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL wrun_done: got %b want 1", done); end
    rd_addr = 3'd0; #1;
    checks++; if (rd_data !== 16'h0005) begin errors++; $display("FAIL wrun_word0: got %h want 0005", rd_data); end
    rd_addr = 3'd1; #1;
    checks++; if (rd_data !== 16'hABCD) begin errors++; $display("FAIL wrun_word1: got %h want abcd", rd_data); end
    tick();
  endtask

  task automatic test_abort_vs_done();
    pulse_start();
    tick();
    checks++; if (go !== 1'b1) begin errors++; $display("FAIL abdone_go: got %b want 1", go); end
    abort = 1'b1;
    eng_done = 1'b1;
    eng_r = {8{16'hDEAD}};
    tick();
    abort = 1'b0;
    eng_done = 1'b0;
    checks++; if (busy !== 1'b0 || go !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_wins: busy=%b go=%b done=%b want 0/0/0", busy, go, done); end
    for (int i = 0; i < 8; i++) begin
      rd_addr = i[2:0]; #1;
      checks++; if (rd_data !== exp_result[i*16 +: 16]) begin errors++; $display("FAIL abort_result_word%0d: got %h want %h", i, rd_data, exp_result[i*16 +: 16]); end
    end
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    eng_r = '0;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_eng_done: done=%b busy=%b want 0/0", done, busy); end
  endtask

  task automatic test_start_abort_idle();
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_beats_abort: busy=%b want 1", busy); end
    tick();
    checks++; if (go !== 1'b1) begin errors++; $display("FAIL start_abort_go: got %b want 1", go); end
    pulse_start();
    checks++; if (go !== 1'b1) begin errors++; $display("FAIL start_while_busy: go=%b want 1", go); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    pulse_start();
    tick();
    checks++; if (go !== 1'b1) begin errors++; $display("FAIL rmid_go: got %b want 1", go); end
    repeat (3) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checks++; if (go !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rmid_flags: go=%b busy=%b done=%b err=%b want 0", go, busy, done, err); end
    checks++; if ((m | e | n) !== 128'd0) begin errors++; $display("FAIL rmid_operands: m=%h e=%h n=%h want 0", m, e, n); end
    rd_addr = 3'd0; #1;
    checks++; if (rd_data !== 16'h0000) begin errors++; $display("FAIL rmid_result: got %h want 0000", rd_data); end
    eng_r = 128'd5;
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    eng_r = '0;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_late_done: done=%b busy=%b want 0/0", done, busy); end
  endtask

  task automatic test_timeout();
    int k;
    load_ops(128'd2, 128'd3, 128'd13);
    pulse_start();
    tick();
    checks++; if (go !== 1'b1) begin errors++; $display("FAIL to_go: got %b want 1", go); end
`ifdef RSA_SEQ_TIMEOUT_EN
    k = 0;
    while (go === 1'b1 && k < 100) begin
      tick();
      k++;
    end
    checks++; if (k !== 16) begin errors++; $display("FAIL to_cycles: got %0d want 16", k); end
    checks++; if (err !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL to_flags: err=%b done=%b busy=%b want 1/0/0", err, done, busy); end
`else
    k = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (go !== 1'b1) k++;
    end
    checks++; if (k !== 0) begin errors++; $display("FAIL no_timeout: go low in %0d cycles want 0", k); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (go !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL no_timeout_abort: go=%b err=%b want 0/0", go, err); end
`endif
  endtask

  initial begin
    reset_n  = 1'b0;
    wr_en    = 1'b0;
    wr_sel   = 2'd0;
    wr_addr  = 3'd0;
    wr_data  = 16'd0;
    start    = 1'b0;
    abort    = 1'b0;
    eng_done = 1'b0;
    eng_r    = '0;
    rd_addr  = 3'd0;
    exp_result = '0;
    test_reset();
    test_basic_run();
    test_bad_operands();
    test_write_with_start();
    test_write_during_run();
    test_abort_vs_done();
    test_start_abort_idle();
    test_reset_mid_run();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
